// File: rtl/uart_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_link_pkg
//  Description : Shared definitions for the UART link scheduler: frame prefix,
//                frame code constants, scheduler state encoding and a helper
//                that assembles a frame byte.
//  Contents    : c_FRAME_PREFIX, c_CODE_*, c_TX_RESET_BYTE, sched_state_e,
//                make_frame()
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_link_pkg;

    // Every frame byte starts with this two-bit marker.
    localparam logic [1:0] c_FRAME_PREFIX  = 2'b10;

    // Frame type codes carried in bits [5:4].
    localparam logic [1:0] c_CODE_MOTION   = 2'b00;
    localparam logic [1:0] c_CODE_PLACE    = 2'b01;
    localparam logic [1:0] c_CODE_DESTROY  = 2'b10;

    // Value held on tx_data out of reset: a motion frame with a zero nibble.
    localparam logic [7:0] c_TX_RESET_BYTE = {c_FRAME_PREFIX, c_CODE_MOTION, 4'b0000};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } sched_state_e;

    function automatic logic [7:0] make_frame(input logic [1:0] code,
                                              input logic [3:0] nibble);
        return {c_FRAME_PREFIX, code, nibble};
    endfunction

endpackage : uart_link_pkg
`default_nettype wire

// File: rtl/link_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : link_watchdog
//  Description : Receive-side watchdog and obstacle detector register. Any
//                received byte restarts the watchdog and marks the link alive;
//                bytes with a zero upper nibble update the detector flags.
//                After TIMEOUT_CYCLES with no byte the link is declared dead
//                and every detector flag is forced on.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                rx_valid_i      - one-cycle strobe, rx_data_i is valid
//                rx_data_i[7:0]  - received byte
//                detector_o[3:0] - {back,right,left,front}, bit0 = front
//                link_alive_o    - a byte arrived within TIMEOUT_CYCLES
//  Revision    : 1.0 - initial release
// ============================================================================
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic [3:0] detector_o,
    output logic       link_alive_o
);

    localparam int            WW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] c_TIMEOUT      = WW'(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] c_TIMEOUT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] cnt_q, cnt_d;
    logic [3:0]    det_q, det_d;
    logic          alive_q, alive_d;

    always_comb begin
        cnt_d   = cnt_q;
        det_d   = det_q;
        alive_d = alive_q;
        if (rx_valid_i) begin
            cnt_d   = '0;
            alive_d = 1'b1;
            // Only status bytes (upper nibble zero) carry obstacle flags.
            if (rx_data_i[7:4] == 4'b0000) begin
                det_d = rx_data_i[3:0];
            end
        end else if (cnt_q != c_TIMEOUT) begin
            // Counter saturates at the timeout so the dead state is sticky
            // until the next received byte.
            cnt_d = cnt_q + WW'(1);
            if (cnt_q == c_TIMEOUT_LAST) begin
                alive_d = 1'b0;
                det_d   = 4'b1111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            det_q   <= 4'b1111;
            alive_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            det_q   <= det_d;
            alive_q <= alive_d;
        end
    end

    assign detector_o   = det_q;
    assign link_alive_o = alive_q;

endmodule : link_watchdog
`default_nettype wire

// File: rtl/uart_link_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_link_scheduler
//  Description : Schedules one-byte frames towards a UART transmitter.
//                Frames are {2'b10, code, moving_state}. Destroy-beacon has
//                priority over place-beacon, which has priority over motion.
//                A motion frame is sent when the motion nibble changes or the
//                refresh period elapses. Each transferred frame is followed by
//                GAP_CYCLES idle cycles. Receive watchdog lives in
//                link_watchdog.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                moving_state[3:0]     - current motion command nibble
//                pl_beacon_req         - pulse, request place-beacon frame
//                de_beacon_req         - pulse, request destroy-beacon frame
//                tx_ready / tx_valid   - byte handshake towards the UART
//                tx_data[7:0]          - frame byte
//                rx_valid / rx_data    - received byte strobe and data
//                detector[3:0]         - obstacle flags, bit0 = front
//                link_alive            - receive link is alive
//                beacon_busy           - beacon pending or being sent
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_link_scheduler
    import uart_link_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] moving_state,
    input  logic       pl_beacon_req,
    input  logic       de_beacon_req,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [3:0] detector,
    output logic       link_alive,
    output logic       beacon_busy
);

    localparam int            RW             = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RW-1:0] c_REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam int            GW             = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] c_GAP_LAST     = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_e  state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [3:0]    last_nib_q, last_nib_d;
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          pl_pend_q, pl_pend_d;
    logic          de_pend_q, de_pend_d;

    logic          w_xfer;
    logic [1:0]    w_cur_code;
    logic          w_motion_due;

    assign w_xfer       = (state_q == SEND) && tx_ready;
    assign w_cur_code   = tx_data_q[5:4];
    assign w_motion_due = (moving_state != last_nib_q) || (refresh_cnt_q == c_REFRESH_LAST);

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        last_nib_d = last_nib_q;
        gap_cnt_d  = gap_cnt_q;
        // Refresh counter runs in every state and parks at its last value,
        // so an overdue refresh stays pending until a motion frame goes out.
        refresh_cnt_d = (refresh_cnt_q == c_REFRESH_LAST) ? refresh_cnt_q
                                                          : refresh_cnt_q + RW'(1);

        case (state_q)
            IDLE: begin
                // moving_state is captured here only; later changes are caught
                // by the nibble comparison on the next IDLE visit.
                if (de_pend_q) begin
                    state_d   = SEND;
                    tx_data_d = make_frame(c_CODE_DESTROY, moving_state);
                end else if (pl_pend_q) begin
                    state_d   = SEND;
                    tx_data_d = make_frame(c_CODE_PLACE, moving_state);
                end else if (w_motion_due) begin
                    state_d   = SEND;
                    tx_data_d = make_frame(c_CODE_MOTION, moving_state);
                end
            end
            SEND: begin
                if (tx_ready) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    if (w_cur_code == c_CODE_MOTION) begin
                        last_nib_d    = tx_data_q[3:0];
                        refresh_cnt_d = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request wins over the clear of its own transfer, so a request
        // landing on the transfer cycle is kept as a fresh pending beacon.
        pl_pend_d = pl_beacon_req | (pl_pend_q & ~(w_xfer && (w_cur_code == c_CODE_PLACE)));
        de_pend_d = de_beacon_req | (de_pend_q & ~(w_xfer && (w_cur_code == c_CODE_DESTROY)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tx_data_q     <= c_TX_RESET_BYTE;
            last_nib_q    <= 4'b0000;
            refresh_cnt_q <= '0;
            gap_cnt_q     <= '0;
            pl_pend_q     <= 1'b0;
            de_pend_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            last_nib_q    <= last_nib_d;
            refresh_cnt_q <= refresh_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            pl_pend_q     <= pl_pend_d;
            de_pend_q     <= de_pend_d;
        end
    end

    assign tx_valid    = (state_q == SEND);
    assign tx_data     = tx_data_q;
    assign beacon_busy = pl_pend_q | de_pend_q |
                         ((state_q == SEND) && (w_cur_code != c_CODE_MOTION));

    link_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_link_watchdog (
        .clk          (clk),
        .rst          (rst),
        .rx_valid_i   (rx_valid),
        .rx_data_i    (rx_data),
        .detector_o   (detector),
        .link_alive_o (link_alive)
    );

endmodule : uart_link_scheduler
`default_nettype wire

// File: doc/uart_link_scheduler.md
UART_LINK_SCHEDULER -- requirements
Module: uart_link_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 100000, cycles between periodic motion frames.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, maximum cycles without a received byte before the link is declared dead.
REQ-003 SHALL have parameter GAP_CYCLES, default 16, idle cycles enforced after each accepted frame.
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port moving_state  input  4  current motion command nibble.
REQ-007 SHALL have port pl_beacon_req  input  1  one-cycle pulse requesting a place-beacon frame.
REQ-008 SHALL have port de_beacon_req  input  1  one-cycle pulse requesting a destroy-beacon frame.
REQ-009 SHALL have port tx_ready  input  1  UART transmitter can accept a byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a frame to send.
REQ-011 SHALL have port tx_data  output  8  frame byte.
REQ-012 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data holds a received byte.
REQ-013 SHALL have port rx_data  input  8  received byte.
REQ-014 SHALL have port detector  output  4  {back,right,left,front} obstacle flags, bit0 = front.
REQ-015 SHALL have port link_alive  output  1  a byte was received within TIMEOUT_CYCLES.
REQ-016 SHALL have port beacon_busy  output  1  a beacon request is pending or in flight.

Function
REQ-017 SHALL format frames as {2'b10, code[1:0], moving_state}: code 00 = motion, 01 = place beacon, 10 = destroy beacon.
REQ-018 SHALL use FSM states IDLE, SEND and GAP.
REQ-019 SHALL, in IDLE, select at most one frame per cycle with priority destroy > place > motion, then enter SEND the next cycle with tx_valid=1.
REQ-020 SHALL schedule a motion frame when moving_state differs from the last sent nibble, or when the refresh counter reaches REFRESH_CYCLES-1.
REQ-021 SHALL hold tx_data stable and tx_valid high in SEND until a cycle with tx_valid && tx_ready; that cycle is the transfer.
REQ-022 SHALL, on transfer, drop tx_valid the next cycle, stay in GAP for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-023 SHALL latch each beacon request in its own 1-deep pending flag; a repeated request while pending merges; the flag clears on that frame's transfer.
REQ-024 SHALL capture a beacon request arriving in the same cycle as the transfer of its own frame as a new pending request.
REQ-025 SHALL sample moving_state into tx_data only when entering SEND; a change during SEND or GAP produces a further motion frame afterwards.
REQ-026 SHALL reset the refresh counter to 0 on every motion-frame transfer; the counter saturates while waiting.
REQ-027 SHALL load detector <= rx_data[3:0] on rx_valid when rx_data[7:4]==4'b0000, and ignore other bytes apart from the watchdog.
REQ-028 SHALL restart the watchdog on any rx_valid; on reaching TIMEOUT_CYCLES it SHALL clear link_alive and force detector to 4'b1111, both registered.
REQ-029 SHALL set link_alive the cycle after any rx_valid.
REQ-030 SHALL drive beacon_busy as the OR of both pending flags and of SEND carrying a beacon code.

Reset
REQ-031 SHALL set, on rst: FSM=IDLE, tx_valid=0, tx_data=8'h80, detector=4'b1111, link_alive=0, beacon_busy=0, pending flags and counters 0, last-sent nibble 4'b0000.
REQ-032 SHALL, on rst during SEND, drop tx_valid the next cycle and discard the frame without retransmission.

Structure
REQ-033 SHALL place the frame prefix 2'b10, the code constants and the FSM state encoding in the shared package uart_link_pkg.
REQ-034 SHALL implement the receive watchdog and detector register as sub-module link_watchdog.

Verification (bench parameters REFRESH=20, TIMEOUT=50, GAP=2)
REQ-035 SHALL cover: after rst, moving_state=4'b0101 with tx_ready=1 -> frame 8'h85 within 2 cycles, then 8'h85 again 20 cycles after that transfer.
REQ-036 SHALL cover: pl_beacon_req and de_beacon_req in the same cycle, moving_state=4'b0001 -> frames 8'hA1, 8'h91, in order, each separated by 2 gap cycles.
REQ-037 SHALL cover: tx_ready held low for 10 cycles during SEND while moving_state changes -> tx_data stable for all 10 cycles, a motion frame with the new nibble follows.
REQ-038 SHALL cover: rx byte 8'h05 -> detector=4'b0101, link_alive=1; then no rx for 50 cycles -> detector=4'b1111, link_alive=0.
REQ-039 SHALL cover: rst asserted while tx_valid=1 -> tx_valid=0 and tx_data=8'h80 the next cycle, pending beacons cleared.
